// File: rtl/finish_pkg.sv
// finish_pkg
//   Shared constants, types and helpers for the Connect-4 win detector.
//   Board geometry: ROWS x COLS cells, bit index = row*COLS + col,
//   row 0 is the bottom row, col 0 is the lowest bit of each row group.
//   Directions are described by (row delta, column delta); the opposite
//   sense is obtained by negating the step count.
package finish_pkg;

    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int CELLS   = ROWS * COLS;
    localparam int WIN_LEN = 4;

    localparam int CELL_W = 6;
    localparam int ROW_W  = 3;
    localparam int COL_W  = 3;

    typedef logic [CELL_W-1:0]  cell_t;
    typedef logic [ROW_W-1:0]   row_t;
    typedef logic [COL_W-1:0]   col_t;
    typedef logic signed [1:0]  delta_t;

    typedef enum logic [1:0] {
        HORZ = 2'd0,
        VERT = 2'd1,
        DIAG = 2'd2,
        ANTI = 2'd3
    } dir_e;

    // Row delta of one step in the given direction.
    function automatic delta_t dir_dr(input dir_e d);
        return (d == HORZ) ? delta_t'(0) : delta_t'(1);
    endfunction

    // Column delta of one step; ANTI walks up-and-left (index +COLS-1).
    function automatic delta_t dir_dc(input dir_e d);
        delta_t dc;
        case (d)
            HORZ:    dc = delta_t'(1);
            VERT:    dc = delta_t'(0);
            DIAG:    dc = delta_t'(1);
            default: dc = delta_t'(-1);
        endcase
        return dc;
    endfunction

    // Row from cell index using constant compares only (no divider).
    function automatic row_t row_of(input cell_t p);
        row_t r;
        r = '0;
        for (int i = 1; i < ROWS; i++) begin
            if (p >= cell_t'(i * COLS)) begin
                r = row_t'(i);
            end
        end
        return r;
    endfunction

    // Column = index minus the row's base index (constant multiply).
    function automatic col_t col_of(input cell_t p);
        cell_t base;
        cell_t diff;
        base = cell_t'(int'(row_of(p)) * COLS);
        diff = p - base;
        return col_t'(diff);
    endfunction

    function automatic cell_t idx(input row_t r, input col_t c);
        return cell_t'(int'(r) * COLS + int'(c));
    endfunction

endpackage

// File: rtl/finish_line_check.sv
// finish_line_check
//   Counts this player's contiguous pieces through (row, col) along one
//   direction, walking up to WIN_LEN-1 steps each way and stopping at the
//   first empty cell or board edge. The origin cell always counts as
//   occupied. Steps never wrap across a row because bounds are checked on
//   row and column separately, not on the flat index.
//   Optional macro FINISH_WIN_MASK_EN adds run_mask.
// Ports:
//   encoding  in   occupancy bitmap (1 = piece)
//   row, col  in   origin cell
//   dr, dc    in   signed step deltas for this direction
//   run_ok    out  run length through origin >= WIN_LEN
//   run_mask  out  (FINISH_WIN_MASK_EN) cells of the run, zero unless run_ok
module finish_line_check
    import finish_pkg::*;
(
    input  logic [CELLS-1:0] encoding,
    input  row_t             row,
    input  col_t             col,
    input  delta_t           dr,
    input  delta_t           dc,
    output logic             run_ok
`ifdef FINISH_WIN_MASK_EN
    ,
    output logic [CELLS-1:0] run_mask
`endif
);

    // Bit k: the cell k steps away is on-board and occupied.
    logic [WIN_LEN-1:0] fwd_hit;
    logic [WIN_LEN-1:0] bwd_hit;
    // Bit k: every cell from 1..k steps away is occupied (run reaches k).
    logic [WIN_LEN-1:0] fwd_live;
    logic [WIN_LEN-1:0] bwd_live;
    int                 run_len;

`ifdef FINISH_WIN_MASK_EN
    logic [WIN_LEN-1:0][CELLS-1:0] step_mask;
    logic [CELLS-1:0]              mask_acc;
    localparam logic [CELLS-1:0]   ONE_HOT = {{(CELLS-1){1'b0}}, 1'b1};

    assign step_mask[0] = ONE_HOT << idx(row, col);
`endif

    assign fwd_hit[0] = 1'b1;
    assign bwd_hit[0] = 1'b1;

    for (genvar gi = 1; gi < WIN_LEN; gi++) begin : g_step
        int    fr;
        int    fc;
        int    br;
        int    bc;
        cell_t fcell;
        cell_t bcell;
        logic  fhit;
        logic  bhit;

        always_comb begin
            fr    = int'(row) + gi * int'(dr);
            fc    = int'(col) + gi * int'(dc);
            br    = int'(row) - gi * int'(dr);
            bc    = int'(col) - gi * int'(dc);
            fcell = cell_t'(fr * COLS + fc);
            bcell = cell_t'(br * COLS + bc);
            fhit  = (fr >= 0) && (fr < ROWS) && (fc >= 0) && (fc < COLS)
                    && encoding[fcell];
            bhit  = (br >= 0) && (br < ROWS) && (bc >= 0) && (bc < COLS)
                    && encoding[bcell];
        end

        assign fwd_hit[gi] = fhit;
        assign bwd_hit[gi] = bhit;

`ifdef FINISH_WIN_MASK_EN
        assign step_mask[gi] = (fwd_live[gi] ? (ONE_HOT << fcell) : '0)
                             | (bwd_live[gi] ? (ONE_HOT << bcell) : '0);
`endif
    end

    always_comb begin
        fwd_live    = '0;
        bwd_live    = '0;
        fwd_live[0] = fwd_hit[0];
        bwd_live[0] = bwd_hit[0];
        for (int k = 1; k < WIN_LEN; k++) begin
            fwd_live[k] = fwd_live[k-1] & fwd_hit[k];
            bwd_live[k] = bwd_live[k-1] & bwd_hit[k];
        end
        run_len = 1;
        for (int k = 1; k < WIN_LEN; k++) begin
            run_len = run_len + int'(fwd_live[k]) + int'(bwd_live[k]);
        end
        run_ok = (run_len >= WIN_LEN);
    end

`ifdef FINISH_WIN_MASK_EN
    always_comb begin
        mask_acc = '0;
        for (int k = 0; k < WIN_LEN; k++) begin
            mask_acc = mask_acc | step_mask[k];
        end
        run_mask = run_ok ? mask_acc : '0;
    end
`endif

endmodule

// File: rtl/finish_detect.sv
// finish_detect
//   Connect-4 win detector: reports whether the piece just dropped at pos
//   completes a line of WIN_LEN or more of this player's pieces
//   (horizontal, vertical, diagonal or anti-diagonal). One register stage,
//   a new check may start every cycle.
//   Optional macro FINISH_WIN_MASK_EN adds the win_mask output.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   encoding/pos valid, start a check
//   encoding   in   occupancy bitmap, bit = row*COLS + col
//   pos        in   index of the last placed cell (>= CELLS never wins)
//   out_valid  out  registered in_valid
//   done       out  winning line through pos; holds while in_valid is low
//   win_mask   out  (FINISH_WIN_MASK_EN) cells of all winning runs
module finish_detect
    import finish_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [CELLS-1:0] encoding,
    input  cell_t            pos,
    output logic             out_valid,
    output logic             done
`ifdef FINISH_WIN_MASK_EN
    ,
    output logic [CELLS-1:0] win_mask
`endif
);

    logic       pos_ok;
    row_t       row;
    col_t       col;
    logic [3:0] dir_ok;
    logic       done_next;
    logic       valid_reg;
    logic       done_reg;

    assign pos_ok = (pos < cell_t'(CELLS));
    assign row    = row_of(pos);
    assign col    = col_of(pos);

`ifdef FINISH_WIN_MASK_EN
    logic [3:0][CELLS-1:0] dir_mask;
    logic [CELLS-1:0]      mask_next;
    logic [CELLS-1:0]      mask_reg;
`endif

    for (genvar gi = 0; gi < 4; gi++) begin : g_dir
        finish_line_check u_line (
            .encoding (encoding),
            .row      (row),
            .col      (col),
            .dr       (dir_dr(dir_e'(gi))),
            .dc       (dir_dc(dir_e'(gi))),
            .run_ok   (dir_ok[gi])
`ifdef FINISH_WIN_MASK_EN
            ,
            .run_mask (dir_mask[gi])
`endif
        );
    end

    // Out-of-range pos decodes to a garbage cell; gate it off here.
    assign done_next = pos_ok & (|dir_ok);

`ifdef FINISH_WIN_MASK_EN
    always_comb begin
        mask_next = '0;
        if (pos_ok) begin
            for (int k = 0; k < 4; k++) begin
                mask_next = mask_next | dir_mask[k];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
`ifdef FINISH_WIN_MASK_EN
            mask_reg  <= '0;
`endif
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                done_reg <= done_next;
`ifdef FINISH_WIN_MASK_EN
                mask_reg <= mask_next;
`endif
            end
        end
    end

    assign out_valid = valid_reg;
    assign done      = done_reg;
`ifdef FINISH_WIN_MASK_EN
    assign win_mask  = mask_reg;
`endif

endmodule

// File: tb/tb_finish_detect.sv
// tb_finish_detect
//   Scoreboard bench for finish_detect: expected results are pushed when a
//   check is driven and popped when out_valid appears. Directed vectors
//   carry hand-derived verdicts; random vectors use a window-enumeration
//   reference model. Build with FINISH_WIN_MASK_EN to also check win_mask.
module tb_finish_detect;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [41:0] encoding;
    logic [5:0]  pos;
    logic        out_valid;
    logic        done;
`ifdef FINISH_WIN_MASK_EN
    logic [41:0] win_mask;
`endif

    finish_detect dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .encoding  (encoding),
        .pos       (pos),
        .out_valid (out_valid),
        .done      (done)
`ifdef FINISH_WIN_MASK_EN
        ,
        .win_mask  (win_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        d;
        logic [41:0] m;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic        last_done;
    logic [41:0] last_mask;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Union of every fully occupied WIN_LEN window that contains p.
    function automatic logic [41:0] ref_mask(input logic [41:0] enc, input int p);
        int          dr [4] = '{0, 1, 1, 1};
        int          dc [4] = '{1, 0, 1, -1};
        logic [41:0] e;
        logic [41:0] w;
        logic [41:0] acc;
        int          r0, c0, r, c;
        bit          ok;
        acc = '0;
        if (p < 0 || p >= 42) return acc;
        e = enc;
        e[6'(p)] = 1'b1;
        r0 = p / 7;
        c0 = p % 7;
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 4; s++) begin
                ok = 1'b1;
                w  = '0;
                for (int k = 0; k < 4; k++) begin
                    r = r0 + (k - s) * dr[d];
                    c = c0 + (k - s) * dc[d];
                    if (r < 0 || r >= 6 || c < 0 || c >= 7) ok = 1'b0;
                    else if (!e[6'(r * 7 + c)]) ok = 1'b0;
                    else w[6'(r * 7 + c)] = 1'b1;
                end
                if (ok) acc = acc | w;
            end
        end
        return acc;
    endfunction

    function automatic logic [41:0] bits4(input int a, input int b, input int c, input int d);
        logic [41:0] v;
        v = '0;
        v[6'(a)] = 1'b1;
        v[6'(b)] = 1'b1;
        v[6'(c)] = 1'b1;
        v[6'(d)] = 1'b1;
        return v;
    endfunction

    // One clock of stimulus plus the check of what the DUT produced.
    // exp_done < 0 takes the verdict from the reference model.
    task automatic step(input string tag, input logic rst, input logic iv,
                        input logic [41:0] enc, input int p, input int exp_done);
        exp_t e;
        rst_n    = rst;
        in_valid = iv;
        encoding = enc;
        pos      = 6'(p);
        if (rst && iv) begin
            e.m = ref_mask(enc, p);
            e.d = (exp_done < 0) ? (e.m != '0) : exp_done[0];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            sb.delete();
            check({tag, "/rst_valid"}, 64'(out_valid), 64'd0);
            check({tag, "/rst_done"}, 64'(done), 64'd0);
            last_done = 1'b0;
            last_mask = '0;
        end else begin
            check({tag, "/out_valid"}, 64'(out_valid), 64'(iv));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check({tag, "/sb_empty"}, 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check({tag, "/done"}, 64'(done), 64'(e.d));
                    last_done = e.d;
                    last_mask = e.m;
                end
            end else begin
                check({tag, "/hold"}, 64'(done), 64'(last_done));
            end
`ifdef FINISH_WIN_MASK_EN
            check({tag, "/mask"}, 64'(win_mask), 64'(last_mask));
`endif
        end
        $display("txn %-10s rst_n=%0b in_valid=%0b pos=%0d out_valid=%0b done=%0b",
                 tag, rst, iv, p, out_valid, done);
    endtask

    logic [41:0] enc_r;

    initial begin
        last_done = 1'b0;
        last_mask = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        encoding  = '0;
        pos       = '0;

        // Reset dominates in_valid.
        step("reset", 1'b0, 1'b1, 42'hF, 0, 1);
        step("reset", 1'b0, 1'b1, 42'hF, 0, 1);
        step("idle", 1'b1, 1'b0, 42'hF, 0, 0);

        // Directed vectors.
        step("h_win", 1'b1, 1'b1, 42'b1111, 0, 1);
        step("h_gap", 1'b1, 1'b1, 42'b11101, 0, 0);
        step("v_win", 1'b1, 1'b1, bits4(0, 7, 14, 21), 0, 1);
        step("v_bent", 1'b1, 1'b1, bits4(0, 7, 15, 23), 0, 0);
        step("d_win", 1'b1, 1'b1, bits4(0, 8, 16, 24), 0, 1);
        step("d_bent", 1'b1, 1'b1, bits4(0, 8, 15, 22), 0, 0);
        step("a_mid", 1'b1, 1'b1, bits4(3, 9, 15, 21), 15, 1);
        step("wrap", 1'b1, 1'b1, bits4(5, 6, 7, 8), 6, 0);
        step("top_row", 1'b1, 1'b1, bits4(38, 39, 40, 41), 41, 1);
        step("pos42", 1'b1, 1'b1, {42{1'b1}}, 42, 0);
        step("pos_forced", 1'b1, 1'b1, 42'b1110, 0, 1);
        step("long_run", 1'b1, 1'b1, 42'h7F, 3, 1);

        // Back-to-back alternation.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step("b2b_win", 1'b1, 1'b1, 42'b1111, 0, 1);
            else            step("b2b_gap", 1'b1, 1'b1, 42'b11101, 0, 0);
        end
        step("b2b_win", 1'b1, 1'b1, 42'b1111, 0, 1);

        // in_valid low: done must hold even with a non-winning input.
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b1, 1'b0, 42'b11101, 0, 0);
        end

        // Random boards against the reference model.
        for (int i = 0; i < 60; i++) begin
            enc_r = {10'($urandom), $urandom};
            if (i % 3 == 1) enc_r = enc_r & {10'($urandom), $urandom};
            if (i % 3 == 2) enc_r = enc_r | {10'($urandom), $urandom};
            step("random", 1'b1, ($urandom_range(0, 4) != 0), enc_r,
                 int'($urandom_range(0, 43)), -1);
        end

        // Reset with a check in flight discards it.
        step("pre_rst", 1'b1, 1'b1, 42'b1111, 0, 1);
        step("mid_rst", 1'b0, 1'b1, 42'b1111, 0, 1);
        step("post_rst", 1'b1, 1'b0, 42'b1111, 0, 0);

        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
